// File: rtl/bch_chien_serial_pkg.sv
// Shared BCH Chien-search types, parameter word and GF(2^m) constant helpers.
// Used by bch_chien_serial (optional feature macro: BCH_CHIEN_ERR_CHECK_EN).
package bch_chien_serial_pkg;

   typedef struct packed {
      int m;
      int t;
      int n;
      int k;
   } bch_params_t;

   localparam bch_params_t BCH_15_7 = '{m: 32'sd4, t: 32'sd2, n: 32'sd15, k: 32'sd7};

   localparam int GF_MAX_M = 16;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } chien_state_t;

   function automatic int clog2_min1(input int v);
      return ($clog2(v) < 1) ? 1 : $clog2(v);
   endfunction

   function automatic int sigma_sz(input bch_params_t p);
      return (p.t + 1) * p.m;
   endfunction

   function automatic int err_sz(input bch_params_t p);
      return clog2_min1(p.t + 1);
   endfunction

   // Primitive polynomial for GF(2^m), including the x^m term.
   function automatic logic [GF_MAX_M:0] prim_poly(input int m);
      logic [GF_MAX_M:0] poly;
      case (m)
         32'sd3:  poly = 17'h0000B;
         32'sd4:  poly = 17'h00013;
         32'sd5:  poly = 17'h00025;
         32'sd6:  poly = 17'h00043;
         32'sd7:  poly = 17'h00089;
         32'sd8:  poly = 17'h0011D;
         32'sd9:  poly = 17'h00211;
         32'sd10: poly = 17'h00409;
         32'sd11: poly = 17'h00805;
         32'sd12: poly = 17'h01053;
         default: poly = 17'h00013;
      endcase
      return poly;
   endfunction

   // Shift-and-reduce GF multiply; with a constant operand this folds to an XOR matrix.
   function automatic logic [GF_MAX_M-1:0] gf_mul(input logic [GF_MAX_M-1:0] a,
                                                  input logic [GF_MAX_M-1:0] b,
                                                  input int m);
      logic [GF_MAX_M:0]   aa;
      logic [GF_MAX_M-1:0] acc;
      logic                take;
      acc = '0;
      aa  = {1'b0, a};
      for (int i = 0; i < GF_MAX_M; i++) begin
         take = (i < m) && (((b >> i) & 16'h0001) != 16'h0000);
         acc  = acc ^ (take ? aa[GF_MAX_M-1:0] : 16'h0000);
         aa   = aa << 1;
         aa   = ((aa >> m) != 17'h00000) ? (aa ^ prim_poly(m)) : aa;
      end
      return acc;
   endfunction

   function automatic logic [GF_MAX_M-1:0] alpha_pow(input int e, input int m);
      logic [GF_MAX_M-1:0] r;
      int                  n;
      n = e % ((32'sd1 << m) - 32'sd1);
      r = 16'h0001;
      for (int i = 0; i < n; i++) begin
         r = gf_mul(r, 16'h0002, m);
      end
      return r;
   endfunction

endpackage

// File: rtl/bch_chien_serial_reg.sv
// One Chien term register: loads sigma_i*alpha^(I*S) on accept, multiplies by alpha^I per beat.
module bch_chien_serial_reg
   import bch_chien_serial_pkg::*;
#(
   parameter bch_params_t P = BCH_15_7,
   parameter int          I = 0
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           load,
   input  logic           step,
   input  logic [P.m-1:0] sigma_i,
   output logic [P.m-1:0] term
);

   localparam int M = P.m;
   localparam int S = (32'sd1 << M) - 32'sd1 - P.n;
   localparam logic [GF_MAX_M-1:0] LOAD_K = alpha_pow(I * S, M);
   localparam logic [GF_MAX_M-1:0] STEP_K = alpha_pow(I, M);

   logic [M-1:0]          term_r;
   logic [GF_MAX_M-1:0]   load_prod_s;
   logic [GF_MAX_M-1:0]   step_prod_s;

   // constant multipliers for load and step
   always_comb begin
      load_prod_s = gf_mul(GF_MAX_M'(sigma_i), LOAD_K, M);
      step_prod_s = gf_mul(GF_MAX_M'(term_r), STEP_K, M);
   end

   // term register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         term_r <= '0;
      end else if (load) begin
         term_r <= load_prod_s[M-1:0];
      end else if (step) begin
         term_r <= step_prod_s[M-1:0];
      end else begin
         term_r <= term_r;
      end
   end

   assign term = term_r;

endmodule

// File: rtl/bch_chien_serial.sv
// Serial Chien search: one data-bit error flag per beat with backpressure.
// Optional root-count check enabled by `define BCH_CHIEN_ERR_CHECK_EN.
module bch_chien_serial
   import bch_chien_serial_pkg::*;
#(
   parameter bch_params_t P = BCH_15_7
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   sigma_valid,
   input  logic [sigma_sz(P)-1:0] sigma,
   input  logic [err_sz(P)-1:0]   err_count,
   output logic                   sigma_accepted,
   output logic                   busy,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_err,
   output logic                   out_last,
   output logic                   out_fail
);

   localparam int M     = P.m;
   localparam int T     = P.t;
   localparam int K     = P.k;
   localparam int POS_W = clog2_min1(K);
   localparam int ERR_W = err_sz(P);

   chien_state_t     state_r;
   chien_state_t     state_nxt_s;
   logic             accept_s;
   logic             beat_s;
   logic             run_s;
   logic             last_s;
   logic [POS_W-1:0] pos_r;
   logic             zero_sigma_r;
   logic [M-1:0]     term_s [0:T];
   logic [M-1:0]     sum_s;

   // next-state and handshake decode
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      beat_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            accept_s    = sigma_valid;
            state_nxt_s = sigma_valid ? ST_RUN : ST_IDLE;
         end
         ST_RUN: begin
            beat_s      = out_ready;
            state_nxt_s = (out_ready && last_s) ? ST_IDLE : ST_RUN;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // position counter; wraps past K-1 harmlessly, reloaded on every accept
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pos_r <= '0;
      end else if (accept_s) begin
         pos_r <= '0;
      end else if (beat_s) begin
         pos_r <= pos_r + POS_W'(1);
      end else begin
         pos_r <= pos_r;
      end
   end

   // an all-zero sigma evaluates to zero everywhere, so flag it to suppress false roots
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         zero_sigma_r <= 1'b0;
      end else if (accept_s) begin
         zero_sigma_r <= (sigma == '0);
      end else begin
         zero_sigma_r <= zero_sigma_r;
      end
   end

   for (genvar i = 0; i <= T; i++) begin : g_term
      bch_chien_serial_reg #(
         .P (P),
         .I (i)
      ) u_term (
         .clk     (clk),
         .reset_n (reset_n),
         .load    (accept_s),
         .step    (beat_s),
         .sigma_i (sigma[i*M +: M]),
         .term    (term_s[i])
      );
   end

   // sigma(alpha^(S+pos)) as XOR of all terms
   always_comb begin
      sum_s = '0;
      for (int i = 0; i <= T; i++) begin
         sum_s = sum_s ^ term_s[i];
      end
   end

   assign run_s          = (state_r == ST_RUN);
   assign last_s         = (pos_r == POS_W'(K - 1));
   assign sigma_accepted = accept_s;
   assign busy           = run_s;
   assign out_valid      = run_s;
   assign out_last       = run_s && last_s;
   assign out_err        = run_s && !zero_sigma_r && (sum_s == '0);

`ifdef BCH_CHIEN_ERR_CHECK_EN
   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

   logic [ERR_W-1:0] root_cnt_r;
   logic [ERR_W-1:0] err_cnt_r;
   logic [ERR_W:0]   found_s;

   // saturating root counter; err_count captured so upstream may change it after accept
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         root_cnt_r <= '0;
         err_cnt_r  <= '0;
      end else if (accept_s) begin
         root_cnt_r <= '0;
         err_cnt_r  <= err_count;
      end else if (beat_s && out_err && (root_cnt_r != ERR_MAX)) begin
         root_cnt_r <= root_cnt_r + ERR_W'(1);
         err_cnt_r  <= err_cnt_r;
      end else begin
         root_cnt_r <= root_cnt_r;
         err_cnt_r  <= err_cnt_r;
      end
   end

   assign found_s  = {1'b0, root_cnt_r} + {{ERR_W{1'b0}}, out_err};
   assign out_fail = out_last && (found_s != {1'b0, err_cnt_r});
`else
   logic unused_err_count_s;
   assign unused_err_count_s = ^err_count;
   assign out_fail           = 1'b0;
`endif

endmodule
